// File: rtl/queen_position_stack_pkg.sv
// Shared sizing and FSM encoding for the 8-Queen position stack.
package queen_position_stack_pkg;
  localparam int Q_DEPTH = 8;
  localparam int Q_ROW_W = 3;
  localparam int Q_COL_W = 3;
  localparam int Q_PTR_W = 4;

  typedef enum logic [1:0] {
    ST_READY   = 2'd0,
    ST_PUSH_WR = 2'd1,
    ST_POP_RD  = 2'd2
  } stk_state_e;
endpackage

// File: rtl/queen_position_stack_mem.sv
// Register file of queen positions: one synchronous write port, two async read ports.
module queen_position_stack_mem #(
  parameter int DEPTH = 8,
  parameter int ROW_W = 3,
  parameter int COL_W = 3,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [ROW_W-1:0] wrow_i,
  input  logic [COL_W-1:0] wcol_i,
  input  logic [AW-1:0]    raddr_a_i,
  output logic [ROW_W-1:0] row_a_o,
  output logic [COL_W-1:0] col_a_o,
  input  logic [AW-1:0]    raddr_b_i,
  output logic [ROW_W-1:0] row_b_o,
  output logic [COL_W-1:0] col_b_o
);
  logic [DEPTH-1:0][ROW_W+COL_W-1:0] mem_q;

  // Contents survive reset and clear; only sp decides what is live.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= {wrow_i, wcol_i};
  end

  assign {row_a_o, col_a_o} = mem_q[raddr_a_i];
  assign {row_b_o, col_b_o} = mem_q[raddr_b_i];
endmodule

// File: rtl/queen_position_stack.sv
// LIFO of placed queens: push/pop FSM with busy handshake, sticky flags and peek port.
module queen_position_stack
  import queen_position_stack_pkg::*;
#(
  parameter int DEPTH = Q_DEPTH,
  parameter int ROW_W = Q_ROW_W,
  parameter int COL_W = Q_COL_W,
  parameter int PTR_W = Q_PTR_W
) (
  input  logic             clk,
  input  logic             user_reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [ROW_W-1:0] push_row,
  input  logic [COL_W-1:0] push_col,
  input  logic [PTR_W-1:0] peek_index,
  output logic [ROW_W-1:0] peek_row,
  output logic [COL_W-1:0] peek_col,
  output logic [ROW_W-1:0] top_row,
  output logic [COL_W-1:0] top_col,
  output logic             pop_valid,
  output logic             stack_ready,
  output logic             underflow,
  output logic             overflow,
  output logic [PTR_W-1:0] depth
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] SP_FULL = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] SP_ONE  = PTR_W'(1);

  stk_state_e       state_q, state_d;
  logic [PTR_W-1:0] sp_q, sp_d;
  logic [ROW_W-1:0] row_q, row_d, top_row_q, top_row_d, rd_row, pk_row;
  logic [COL_W-1:0] col_q, col_d, top_col_q, top_col_d, rd_col, pk_col;
  logic             rdy_q, rdy_d, uf_q, uf_d, of_q, of_d, pv_q, pv_d, we;

  queen_position_stack_mem #(.DEPTH(DEPTH), .ROW_W(ROW_W), .COL_W(COL_W)) u_mem (
    .clk       (clk),
    .we_i      (we),
    .waddr_i   (sp_q[AW-1:0]),
    .wrow_i    (row_q),
    .wcol_i    (col_q),
    .raddr_a_i (peek_index[AW-1:0]),
    .row_a_o   (pk_row),
    .col_a_o   (pk_col),
    .raddr_b_i (sp_q[AW-1:0]),
    .row_b_o   (rd_row),
    .col_b_o   (rd_col)
  );

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    row_d     = row_q;
    col_d     = col_q;
    top_row_d = top_row_q;
    top_col_d = top_col_q;
    rdy_d     = rdy_q;
    uf_d      = uf_q;
    of_d      = of_q;
    pv_d      = 1'b0;
    we        = 1'b0;
    if (clear) begin
      state_d   = ST_READY;
      sp_d      = '0;
      top_row_d = '0;
      top_col_d = '0;
      rdy_d     = 1'b1;
      uf_d      = 1'b0;
      of_d      = 1'b0;
    end else begin
      case (state_q)
        ST_READY: begin
          // Pop outranks push; a simultaneous push is simply dropped.
          if (pop) begin
            if (sp_q == '0) begin
              uf_d = 1'b1;
            end else begin
              sp_d    = sp_q - SP_ONE;
              state_d = ST_POP_RD;
              rdy_d   = 1'b0;
              of_d    = 1'b0;
            end
          end else if (push) begin
            if (sp_q == SP_FULL) begin
              of_d = 1'b1;
            end else begin
              row_d   = push_row;
              col_d   = push_col;
              state_d = ST_PUSH_WR;
              rdy_d   = 1'b0;
              uf_d    = 1'b0;
            end
          end
        end
        ST_PUSH_WR: begin
          we      = 1'b1;
          sp_d    = sp_q + SP_ONE;
          state_d = ST_READY;
          rdy_d   = 1'b1;
        end
        ST_POP_RD: begin
          // sp already points at the popped slot.
          top_row_d = rd_row;
          top_col_d = rd_col;
          pv_d      = 1'b1;
          state_d   = ST_READY;
          rdy_d     = 1'b1;
        end
        default: begin
          state_d = ST_READY;
          rdy_d   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge user_reset_n) begin
    if (!user_reset_n) begin
      state_q   <= ST_READY;
      sp_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      top_row_q <= '0;
      top_col_q <= '0;
      rdy_q     <= 1'b1;
      uf_q      <= 1'b0;
      of_q      <= 1'b0;
      pv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      sp_q      <= sp_d;
      row_q     <= row_d;
      col_q     <= col_d;
      top_row_q <= top_row_d;
      top_col_q <= top_col_d;
      rdy_q     <= rdy_d;
      uf_q      <= uf_d;
      of_q      <= of_d;
      pv_q      <= pv_d;
    end
  end

  assign peek_row    = (peek_index < sp_q) ? pk_row : '0;
  assign peek_col    = (peek_index < sp_q) ? pk_col : '0;
  assign top_row     = top_row_q;
  assign top_col     = top_col_q;
  assign pop_valid   = pv_q;
  assign stack_ready = rdy_q;
  assign underflow   = uf_q;
  assign overflow    = of_q;
  assign depth       = sp_q;
endmodule

// File: tb/tb_queen_position_stack.sv
// Directed bench: stimulus queues expected pops, a negedge monitor checks each pop_valid.
module tb_queen_position_stack;
  logic       clk = 1'b0;
  logic       user_reset_n, clear, push, pop;
  logic [2:0] push_row, push_col, peek_row, peek_col, top_row, top_col;
  logic [3:0] peek_index, depth;
  logic       pop_valid, stack_ready, underflow, overflow;

  int         total = 0;
  int         bad = 0;
  int         pv_seen = 0;
  int         pv_exp = 0;
  logic [5:0] exp_q[$];
  logic [5:0] mon_e;

  queen_position_stack dut (
    .clk(clk), .user_reset_n(user_reset_n), .clear(clear), .push(push), .pop(pop),
    .push_row(push_row), .push_col(push_col), .peek_index(peek_index),
    .peek_row(peek_row), .peek_col(peek_col), .top_row(top_row), .top_col(top_col),
    .pop_valid(pop_valid), .stack_ready(stack_ready), .underflow(underflow),
    .overflow(overflow), .depth(depth)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pop(input int r, input int c);
    exp_q.push_back({r[2:0], c[2:0]});
    pv_exp++;
  endtask

  task automatic do_push(input int r, input int c);
    push = 1'b1; push_row = r[2:0]; push_col = c[2:0];
    step();
    push = 1'b0;
    chk("push_busy", int'(stack_ready), 0);
    step();
    chk("push_done_ready", int'(stack_ready), 1);
  endtask

  task automatic chk_peek(input string name, input int idx, input int r, input int c);
    peek_index = idx[3:0];
    #1;
    chk({name, "_row"}, int'(peek_row), r);
    chk({name, "_col"}, int'(peek_col), c);
  endtask

  // Monitor: every pop_valid pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (pop_valid === 1'b1) begin
      pv_seen++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_unexpected: got top %0d/%0d expected no pop_valid", top_row, top_col);
      end else begin
        mon_e = exp_q.pop_front();
        if ({top_row, top_col} !== mon_e) begin
          bad++;
          $display("FAIL pop_top: got %0d/%0d expected %0d/%0d",
                   top_row, top_col, mon_e[5:3], mon_e[2:0]);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    user_reset_n = 1'b0; clear = 1'b0; push = 1'b0; pop = 1'b0;
    push_row = '0; push_col = '0; peek_index = '0;
    step(); step();
    chk("rst_ready", int'(stack_ready), 1);
    chk("rst_depth", int'(depth), 0);
    chk("rst_underflow", int'(underflow), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_pop_valid", int'(pop_valid), 0);
    user_reset_n = 1'b1;
    step();

    // single push, then peek
    do_push(0, 3);
    chk("push1_depth", int'(depth), 1);
    chk_peek("peek0", 0, 0, 3);
    chk_peek("peek_above_sp", 1, 0, 0);

    // fill to DEPTH, then overflow
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear_depth", int'(depth), 0);
    for (int i = 0; i < 8; i++) do_push(i, 7 - i);
    chk("full_depth", int'(depth), 8);
    push = 1'b1; push_row = 3'd5; push_col = 3'd5;
    step();
    push = 1'b0;
    chk("ovf_ready", int'(stack_ready), 1);
    chk("ovf_flag", int'(overflow), 1);
    chk("ovf_depth", int'(depth), 8);
    chk_peek("ovf_peek7", 7, 7, 0);
    chk_peek("ovf_peek0", 0, 0, 7);
    chk_peek("ovf_peek8", 8, 0, 0);

    // successful pop clears overflow
    expect_pop(7, 0);
    pop = 1'b1; step(); pop = 1'b0;
    chk("pop_clr_ovf", int'(overflow), 0);
    chk("pop_full_depth", int'(depth), 7);
    step();
    step();

    // clear returns top to zero
    clear = 1'b1; step(); clear = 1'b0;
    chk("clear2_depth", int'(depth), 0);
    chk("clear2_top", int'(top_row), 0);

    // single pop from depth 3
    for (int i = 0; i < 3; i++) do_push(i, 7 - i);
    expect_pop(2, 5);
    pop = 1'b1; step(); pop = 1'b0;
    chk("pop3_busy", int'(stack_ready), 0);
    chk("pop3_depth", int'(depth), 2);
    step();
    chk("pop3_ready", int'(stack_ready), 1);
    chk("pop3_pv", int'(pop_valid), 1);
    chk("pop3_top_row", int'(top_row), 2);
    step();
    chk("pop3_pv_end", int'(pop_valid), 0);

    // drain with pop held high
    expect_pop(1, 6);
    expect_pop(0, 7);
    pop = 1'b1;
    repeat (5) step();
    pop = 1'b0;
    chk("drain_underflow", int'(underflow), 1);
    chk("drain_depth", int'(depth), 0);
    chk("drain_ready", int'(stack_ready), 1);
    chk("drain_top_row", int'(top_row), 0);
    chk("drain_top_col", int'(top_col), 7);

    // push and pop together: pop wins
    do_push(3, 4);
    chk("push_clr_uf", int'(underflow), 0);
    expect_pop(3, 4);
    push = 1'b1; pop = 1'b1; push_row = 3'd6; push_col = 3'd6;
    step();
    push = 1'b0; pop = 1'b0;
    step();
    chk("both_depth", int'(depth), 0);
    chk("both_top_col", int'(top_col), 4);
    step();

    // clear during PUSH_WR aborts the write
    do_push(4, 4);
    push = 1'b1; push_row = 3'd5; push_col = 3'd1;
    step();
    push = 1'b0; clear = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_wr_depth", int'(depth), 0);
    chk("clr_wr_ready", int'(stack_ready), 1);
    chk("clr_wr_pv", int'(pop_valid), 0);
    step();

    // async reset mid-POP_RD
    do_push(1, 2);
    pop = 1'b1; step(); pop = 1'b0;
    chk("prerst_busy", int'(stack_ready), 0);
    #2 user_reset_n = 1'b0;
    #1;
    chk("arst_ready", int'(stack_ready), 1);
    chk("arst_depth", int'(depth), 0);
    chk("arst_pv", int'(pop_valid), 0);
    chk("arst_top_row", int'(top_row), 0);
    step(); step();
    user_reset_n = 1'b1;
    step(); step();

    chk("scoreboard_empty", exp_q.size(), 0);
    chk("pop_valid_count", pv_seen, pv_exp);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
